// File: rtl/ahb_mtx_input_hold_stage.sv
// Per-master input stage of the AHB bus matrix. It holds an address phase the
// arbiter cannot take yet, stalls the master, and forwards held or live
// address/control to the per-slave output muxes.
module ahb_mtx_input_hold_stage #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PROT_WIDTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [PROT_WIDTH-1:0] HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  req_port,
    output logic                  sel_i,
    output logic [ADDR_WIDTH-1:0] addr_i,
    output logic [1:0]            trans_i,
    output logic                  write_i,
    output logic [2:0]            size_i,
    output logic [2:0]            burst_i,
    output logic [PROT_WIDTH-1:0] prot_i,
    output logic                  lock_i,
    input  logic                  granted,
    input  logic                  HREADYM,
    input  logic                  HRESPM
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    data_phase_q, data_phase_d;
    logic                    hsel_q;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic [1:0]              htrans_q;
    logic                    hwrite_q;
    logic [2:0]              hsize_q;
    logic [2:0]              hburst_q;
    logic [PROT_WIDTH-1:0]   hprot_q;
    logic                    hlock_q;

    logic pend;
    logic capture;
    logic accept;
    logic load;
    logic dp_start;

    assign pend    = (state_q == ST_PEND);
    assign capture = HSELS & HREADYS & HTRANSS[1];
    assign accept  = granted & HREADYM;
    assign load    = HREADYS & ~pend;

    // Live inputs are only a valid address phase when HREADYS is high;
    // a held phase is always valid.
    assign dp_start = accept & sel_i & trans_i[1] & (pend | HREADYS);

    always_comb begin
        state_d      = state_q;
        data_phase_d = data_phase_q;
        case (state_q)
            ST_IDLE: if (capture && !accept) state_d = ST_PEND;
            ST_PEND: if (accept)             state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
        if (HREADYM) data_phase_d = dp_start;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            data_phase_q <= 1'b0;
            hsel_q       <= 1'b0;
            haddr_q      <= '0;
            htrans_q     <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hburst_q     <= '0;
            hprot_q      <= '0;
            hlock_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_phase_q <= data_phase_d;
            if (load) begin
                hsel_q   <= HSELS;
                haddr_q  <= HADDRS;
                htrans_q <= HTRANSS;
                hwrite_q <= HWRITES;
                hsize_q  <= HSIZES;
                hburst_q <= HBURSTS;
                hprot_q  <= HPROTS;
                hlock_q  <= HMASTLOCKS;
            end
        end
    end

    always_comb begin
        if (pend) begin
            sel_i   = hsel_q;
            addr_i  = haddr_q;
            trans_i = htrans_q;
            write_i = hwrite_q;
            size_i  = hsize_q;
            burst_i = hburst_q;
            prot_i  = hprot_q;
            lock_i  = hlock_q;
        end else begin
            sel_i   = HSELS;
            addr_i  = HADDRS;
            trans_i = HTRANSS;
            write_i = HWRITES;
            size_i  = HSIZES;
            burst_i = HBURSTS;
            prot_i  = HPROTS;
            lock_i  = HMASTLOCKS;
        end
    end

    assign req_port   = pend | (HSELS & HTRANSS[1]);
    assign HREADYOUTS = pend ? 1'b0 : (data_phase_q ? HREADYM : 1'b1);
    assign HRESPS     = data_phase_q & HRESPM;

endmodule

// File: tb/tb_ahb_mtx_input_hold_stage.sv
// Directed bench for the AHB matrix input hold stage: reset, pass-through,
// hold/stall, burst, ERROR response, mid-operation reset and back-to-back.
module tb_ahb_mtx_input_hold_stage;

    localparam int unsigned AW = 32;
    localparam int unsigned PW = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [PW-1:0] HPROTS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic          HRESPS;
    logic          req_port;
    logic          sel_i;
    logic [AW-1:0] addr_i;
    logic [1:0]    trans_i;
    logic          write_i;
    logic [2:0]    size_i;
    logic [2:0]    burst_i;
    logic [PW-1:0] prot_i;
    logic          lock_i;
    logic          granted;
    logic          HREADYM;
    logic          HRESPM;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_input_hold_stage #(
        .ADDR_WIDTH(AW),
        .PROT_WIDTH(PW)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .req_port(req_port),
        .sel_i(sel_i), .addr_i(addr_i), .trans_i(trans_i), .write_i(write_i),
        .size_i(size_i), .burst_i(burst_i), .prot_i(prot_i), .lock_i(lock_i),
        .granted(granted), .HREADYM(HREADYM), .HRESPM(HRESPM)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'hDEAD_0000;
        granted = 1'b0; HREADYM = 1'b1; HREADYS = 1'b1; HRESPM = 1'b0;
        step(); step();
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL rst_during_hready: got %b want 1", HREADYOUTS); end
        HRESETn = 1'b1; HSELS = 1'b0; HTRANSS = 2'b00;
        step();
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL rst_hready: got %b want 1", HREADYOUTS); end
        n_cmp++; if (req_port !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", req_port); end
        n_cmp++; if (HRESPS !== 1'b0) begin n_bad++; $display("FAIL rst_resp: got %b want 0", HRESPS); end
        n_cmp++; if (sel_i !== 1'b0) begin n_bad++; $display("FAIL rst_sel_live: got %b want 0", sel_i); end
    endtask

    task automatic test_pass_through();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_1000; HWRITES = 1'b1;
        granted = 1'b1; HREADYM = 1'b1; HREADYS = 1'b1;
        #1;
        n_cmp++; if (req_port !== 1'b1) begin n_bad++; $display("FAIL pt_req: got %b want 1", req_port); end
        n_cmp++; if (addr_i !== 32'h0000_1000) begin n_bad++; $display("FAIL pt_addr: got %h want 00001000", addr_i); end
        n_cmp++; if (write_i !== 1'b1) begin n_bad++; $display("FAIL pt_write: got %b want 1", write_i); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL pt_hready0: got %b want 1", HREADYOUTS); end
        step();
        HSELS = 1'b0; HTRANSS = 2'b00; HREADYM = 1'b0; granted = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL pt_dp_wait: got %b want 0", HREADYOUTS); end
        n_cmp++; if (req_port !== 1'b0) begin n_bad++; $display("FAIL pt_idle_req: got %b want 0", req_port); end
        HREADYM = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL pt_dp_done: got %b want 1", HREADYOUTS); end
        step();
        HREADYM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL pt_dp_cleared: got %b want 1", HREADYOUTS); end
        HREADYM = 1'b1;
    endtask

    task automatic test_pend();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_2000; HWRITES = 1'b0;
        HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'hA; HMASTLOCKS = 1'b1;
        granted = 1'b0; HREADYM = 1'b1; HREADYS = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL pd_pre_hready: got %b want 1", HREADYOUTS); end
        step();
        HADDRS = 32'h0000_3000; HTRANSS = 2'b11; HPROTS = 4'h5; HMASTLOCKS = 1'b0;
        HSIZES = 3'd0; HREADYS = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL pd_stall: got %b want 0", HREADYOUTS); end
        n_cmp++; if (addr_i !== 32'h0000_2000) begin n_bad++; $display("FAIL pd_addr_held: got %h want 00002000", addr_i); end
        n_cmp++; if (trans_i !== 2'b10) begin n_bad++; $display("FAIL pd_trans_held: got %b want 10", trans_i); end
        n_cmp++; if (prot_i !== 4'hA) begin n_bad++; $display("FAIL pd_prot_held: got %h want a", prot_i); end
        n_cmp++; if (lock_i !== 1'b1) begin n_bad++; $display("FAIL pd_lock_held: got %b want 1", lock_i); end
        n_cmp++; if (size_i !== 3'd2) begin n_bad++; $display("FAIL pd_size_held: got %0d want 2", size_i); end
        n_cmp++; if (req_port !== 1'b1) begin n_bad++; $display("FAIL pd_req: got %b want 1", req_port); end
        HREADYS = 1'b1;
        step();
        n_cmp++; if (addr_i !== 32'h0000_2000) begin n_bad++; $display("FAIL pd_frozen: got %h want 00002000", addr_i); end
        HREADYS = 1'b0;
        step();
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL pd_stall3: got %b want 0", HREADYOUTS); end
        granted = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL pd_grant_still_stall: got %b want 0", HREADYOUTS); end
        step();
        HSELS = 1'b0; HTRANSS = 2'b00; HREADYS = 1'b1; granted = 1'b0; HREADYM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL pd_dp_wait: got %b want 0", HREADYOUTS); end
        n_cmp++; if (addr_i !== 32'h0000_3000) begin n_bad++; $display("FAIL pd_live_after: got %h want 00003000", addr_i); end
        n_cmp++; if (req_port !== 1'b0) begin n_bad++; $display("FAIL pd_req_after: got %b want 0", req_port); end
        HREADYM = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL pd_dp_done: got %b want 1", HREADYOUTS); end
        step();
    endtask

    task automatic test_burst();
        logic [AW-1:0] addrs [4];
        logic [1:0]    trs   [4];
        addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h10C;
        trs[0] = 2'b10; trs[1] = 2'b11; trs[2] = 2'b11; trs[3] = 2'b11;
        granted = 1'b1; HREADYM = 1'b1; HREADYS = 1'b1; HSELS = 1'b1; HBURSTS = 3'd3;
        for (int i = 0; i < 4; i++) begin
            HADDRS = addrs[i]; HTRANSS = trs[i];
            #1;
            n_cmp++; if (addr_i !== addrs[i]) begin n_bad++; $display("FAIL bu_addr%0d: got %h want %h", i, addr_i, addrs[i]); end
            n_cmp++; if (trans_i !== trs[i]) begin n_bad++; $display("FAIL bu_trans%0d: got %b want %b", i, trans_i, trs[i]); end
            n_cmp++; if (burst_i !== 3'd3) begin n_bad++; $display("FAIL bu_burst%0d: got %0d want 3", i, burst_i); end
            n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL bu_nostall%0d: got %b want 1", i, HREADYOUTS); end
            step();
        end
        HSELS = 1'b0; HTRANSS = 2'b00; HBURSTS = 3'd0; HREADYM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL bu_last_dp: got %b want 0", HREADYOUTS); end
        HREADYM = 1'b1;
        step();
    endtask

    task automatic test_error();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_4000;
        granted = 1'b1; HREADYM = 1'b1; HREADYS = 1'b1; HRESPM = 1'b0;
        step();
        HTRANSS = 2'b00; HREADYM = 1'b0; HRESPM = 1'b1; HREADYS = 1'b0;
        #1;
        n_cmp++; if (HRESPS !== 1'b1) begin n_bad++; $display("FAIL er_resp1: got %b want 1", HRESPS); end
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL er_hready1: got %b want 0", HREADYOUTS); end
        n_cmp++; if (req_port !== 1'b0) begin n_bad++; $display("FAIL er_req1: got %b want 0", req_port); end
        step();
        HREADYM = 1'b1; HREADYS = 1'b1;
        #1;
        n_cmp++; if (HRESPS !== 1'b1) begin n_bad++; $display("FAIL er_resp2: got %b want 1", HRESPS); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL er_hready2: got %b want 1", HREADYOUTS); end
        n_cmp++; if (req_port !== 1'b0) begin n_bad++; $display("FAIL er_req2: got %b want 0", req_port); end
        step();
        #1;
        n_cmp++; if (HRESPS !== 1'b0) begin n_bad++; $display("FAIL er_resp_after: got %b want 0", HRESPS); end
        HRESPM = 1'b0; HSELS = 1'b0;
    endtask

    task automatic test_reset_mid();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_5000;
        granted = 1'b0; HREADYM = 1'b1; HREADYS = 1'b1;
        step();
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL rm_pend: got %b want 0", HREADYOUTS); end
        HRESETn = 1'b0; HSELS = 1'b0; HTRANSS = 2'b00;
        #1;
        n_cmp++; if (req_port !== 1'b1) begin n_bad++; $display("FAIL rm_req_before_edge: got %b want 1", req_port); end
        step();
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL rm_hready: got %b want 1", HREADYOUTS); end
        n_cmp++; if (req_port !== 1'b0) begin n_bad++; $display("FAIL rm_req: got %b want 0", req_port); end
        HRESETn = 1'b1; granted = 1'b1;
        step();
        HREADYM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL rm_discarded: got %b want 1", HREADYOUTS); end
        HREADYM = 1'b1; granted = 1'b0;
    endtask

    task automatic test_back_to_back();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_6000;
        granted = 1'b1; HREADYM = 1'b1; HREADYS = 1'b1;
        step();
        HADDRS = 32'h0000_6004;
        #1;
        n_cmp++; if (addr_i !== 32'h0000_6004) begin n_bad++; $display("FAIL bb_addr: got %h want 00006004", addr_i); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_bad++; $display("FAIL bb_nobubble: got %b want 1", HREADYOUTS); end
        n_cmp++; if (req_port !== 1'b1) begin n_bad++; $display("FAIL bb_req: got %b want 1", req_port); end
        step();
        HSELS = 1'b0; HTRANSS = 2'b00; HREADYM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_bad++; $display("FAIL bb_second_dp: got %b want 0", HREADYOUTS); end
        HREADYM = 1'b1;
        step();
    endtask

    initial begin
        HRESETn = 1'b0; HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
        HSIZES = '0; HBURSTS = '0; HPROTS = '0; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
        granted = 1'b0; HREADYM = 1'b1; HRESPM = 1'b0;
        test_reset();
        test_pass_through();
        test_pend();
        test_burst();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
